// File: rtl/ika9958_dlclk_rx.sv
// ---------------------------------------------------------------------------
// ika9958_dlclk_rx
// Recovers the 5.37/10.74 MHz phase enables from an external DLCLK supplied
// by a master VDP, with a lock/holdover tracker around a 4-cycle phase counter.
//
// Ports
//   i_XTAL1       master clock, all flops on posedge
//   i_RST_n       asynchronous active-low reset
//   i_XTAL_NCEN   clock enable; every register advances only when high
//   i_DC          1 = slave to external DLCLK, 0 = free-run
//   i_DLCLK_n     external DLCLK (asynchronous)
//   o_PHIL_*      recovered 5.37 MHz positive/negative enables
//   o_PHIH_*      recovered 10.74 MHz positive/negative enables
//   o_LOCKED      recovered phase is valid (LOCKED or HOLDOVER)
//   o_HOLD        free-running on the last phase after DLCLK was lost
//   o_SLIP_CNT    saturating count of phase corrections made while locked
//   o_STATE       tracker state encoding (see table)
//
// state     | meaning
// IDLE      | free-run, external DLCLK ignored
// UNLOCKED  | waiting for the first DLCLK falling edge
// ACQUIRE   | counting consecutive 4-cycle periods
// LOCKED    | phase valid, checking each edge against the local phase
// HOLDOVER  | edges lost, phase free-runs until reacquired or given up
// ---------------------------------------------------------------------------
module ika9958_dlclk_rx #(
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned TIMEOUT   = 8,
  parameter logic [1:0]  ALIGN_OFS = 2'd3
) (
  input  logic       i_XTAL1,
  input  logic       i_RST_n,
  input  logic       i_XTAL_NCEN,
  input  logic       i_DC,
  input  logic       i_DLCLK_n,
  output logic       o_PHIL_PCEN,
  output logic       o_PHIL_NCEN,
  output logic       o_PHIH_PCEN,
  output logic       o_PHIH_NCEN,
  output logic       o_LOCKED,
  output logic       o_HOLD,
  output logic [7:0] o_SLIP_CNT,
  output logic [2:0] o_STATE
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_ACQUIRE  = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_HOLDOVER = 3'd4
  } state_e;

  localparam logic [3:0] TIMEOUT_V = 4'(TIMEOUT);
  localparam logic [2:0] LOCK_V    = 3'(LOCK_CNT);
  localparam logic [5:0] HOLD_V    = 6'(4 * TIMEOUT);

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q, hist_q;
  logic [1:0] ph_q, ph_d, ph_inc;
  logic [3:0] per_q, per_d;
  logic [2:0] good_q, good_d;
  logic       err_q, err_d;
  logic [5:0] hold_q, hold_d;
  logic [7:0] slip_q, slip_d;
  logic       edge_det, good_per, in_phase, timeout, align;

  // Synchronizer and history flop reset high so reset release never looks
  // like a falling edge.
  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else if (i_XTAL_NCEN) begin
      sync1_q <= i_DLCLK_n;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_det = hist_q & ~sync2_q;
  assign good_per = edge_det && (per_q == 4'd3);
  assign ph_inc   = ph_q + 2'd1;
  // In phase when the free-running phase would already land on the align value.
  assign in_phase = (ph_inc == ALIGN_OFS);
  assign timeout  = (per_q == TIMEOUT_V);

  always_comb begin
    state_d = state_q;
    align   = 1'b0;
    good_d  = good_q;
    err_d   = 1'b0;
    hold_d  = 6'd0;
    slip_d  = slip_q;
    if (edge_det)            per_d = 4'd0;
    else if (per_q == 4'hF)  per_d = per_q;
    else                     per_d = per_q + 4'd1;

    if (!i_DC) begin
      // Counters clear; ph keeps running so free-run enables stay periodic.
      state_d = ST_IDLE;
      per_d   = 4'd0;
      good_d  = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_UNLOCKED;
        ST_UNLOCKED: begin
          if (edge_det) begin
            state_d = ST_ACQUIRE;
            good_d  = 3'd1;
            align   = 1'b1;
          end
        end
        ST_ACQUIRE: begin
          if (edge_det) begin
            align = 1'b1;
            if (good_per) begin
              good_d = good_q + 3'd1;
              if (good_q + 3'd1 == LOCK_V) state_d = ST_LOCKED;
            end else begin
              good_d = 3'd1;
            end
          end else if (timeout) begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          err_d = err_q;
          if (edge_det) begin
            if (in_phase) begin
              err_d = 1'b0;
            end else begin
              align = 1'b1;
              if (slip_q != 8'hFF) slip_d = slip_q + 8'd1;
              if (err_q) begin
                state_d = ST_ACQUIRE;
                good_d  = 3'd1;
                err_d   = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
          end else if (timeout) begin
            state_d = ST_HOLDOVER;
          end
        end
        ST_HOLDOVER: begin
          if (edge_det) begin
            if (in_phase) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_ACQUIRE;
              good_d  = 3'd1;
              align   = 1'b1;
            end
          end else begin
            hold_d = hold_q + 6'd1;
            if (hold_q + 6'd1 == HOLD_V) state_d = ST_UNLOCKED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    ph_d = align ? ALIGN_OFS : ph_inc;
  end

  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= ST_IDLE;
      ph_q    <= 2'd0;
      per_q   <= 4'd0;
      good_q  <= 3'd0;
      err_q   <= 1'b0;
      hold_q  <= 6'd0;
      slip_q  <= 8'd0;
    end else if (i_XTAL_NCEN) begin
      state_q <= state_d;
      ph_q    <= ph_d;
      per_q   <= per_d;
      good_q  <= good_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      slip_q  <= slip_d;
    end
  end

  assign o_PHIL_PCEN = i_XTAL_NCEN & (ph_q == 2'd0);
  assign o_PHIL_NCEN = i_XTAL_NCEN & (ph_q == 2'd2);
  assign o_PHIH_PCEN = i_XTAL_NCEN & ~ph_q[0];
  assign o_PHIH_NCEN = i_XTAL_NCEN & ph_q[0];
  assign o_LOCKED    = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
  assign o_HOLD      = (state_q == ST_HOLDOVER);
  assign o_SLIP_CNT  = slip_q;
  assign o_STATE     = state_q;

endmodule

// File: tb/tb_ika9958_dlclk_rx.sv
module tb_ika9958_dlclk_rx;

  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 8;
  localparam int ALIGN    = 3;

  localparam int M_IDLE = 0, M_UNL = 1, M_ACQ = 2, M_LCK = 3, M_HLD = 4;

  logic clk, rst_n, ncen_r, dc_r, dlclk_n;
  logic phil_p, phil_n, phih_p, phih_n, locked, hold;
  logic [7:0] slip;
  logic [2:0] state;

  ika9958_dlclk_rx #(
    .LOCK_CNT(LOCK_CNT),
    .TIMEOUT(TIMEOUT),
    .ALIGN_OFS(2'd3)
  ) dut (
    .i_XTAL1(clk),
    .i_RST_n(rst_n),
    .i_XTAL_NCEN(ncen_r),
    .i_DC(dc_r),
    .i_DLCLK_n(dlclk_n),
    .o_PHIL_PCEN(phil_p),
    .o_PHIL_NCEN(phil_n),
    .o_PHIH_PCEN(phih_p),
    .o_PHIH_NCEN(phih_n),
    .o_LOCKED(locked),
    .o_HOLD(hold),
    .o_SLIP_CNT(slip),
    .o_STATE(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit slow  = 0;
  logic [3:0] last_en;

  // Reference model: plain integers, stepped once per enabled cycle.
  int m_state, m_ph, m_since, m_good, m_miss, m_hold, m_slip;
  bit m_pin[3];   // [0] oldest sampled pin, [2] newest

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = M_IDLE; m_ph = 0; m_since = 0; m_good = 0;
    m_miss = 0; m_hold = 0; m_slip = 0;
    for (int i = 0; i < 3; i++) m_pin[i] = 1'b1;
  endtask

  function automatic bit m_edge();
    return (m_pin[0] == 1'b1) && (m_pin[1] == 1'b0);
  endfunction

  function automatic logic [3:0] model_en(input logic ncen);
    logic [3:0] r;
    r = 4'b0000;
    if (ncen) r = {m_ph == 0, m_ph == 2, (m_ph % 2) == 0, (m_ph % 2) == 1};
    return r;
  endfunction

  task automatic model_step(input logic pin, input logic dc);
    bit e, gp, inph, al;
    int ns;
    e    = m_edge();
    gp   = e && (m_since == 3);
    inph = (((m_ph + 1) % 4) == ALIGN);
    al   = 0;
    ns   = m_state;
    if (!dc) begin
      ns = M_IDLE; m_good = 0; m_hold = 0;
    end else begin
      case (m_state)
        M_IDLE: ns = M_UNL;
        M_UNL: if (e) begin ns = M_ACQ; m_good = 1; al = 1; end
        M_ACQ: begin
          if (e) begin
            al = 1;
            if (gp) begin
              m_good = m_good + 1;
              if (m_good == LOCK_CNT) ns = M_LCK;
            end else m_good = 1;
          end else if (m_since == TIMEOUT) ns = M_UNL;
        end
        M_LCK: begin
          if (e) begin
            if (inph) m_miss = 0;
            else begin
              al = 1;
              if (m_slip < 255) m_slip = m_slip + 1;
              if (m_miss > 0) begin ns = M_ACQ; m_good = 1; end
              else m_miss = 1;
            end
          end else if (m_since == TIMEOUT) begin ns = M_HLD; m_hold = 0; end
        end
        M_HLD: begin
          if (e) begin
            if (inph) ns = M_LCK;
            else begin ns = M_ACQ; m_good = 1; al = 1; end
          end else begin
            m_hold = m_hold + 1;
            if (m_hold == 4 * TIMEOUT) ns = M_UNL;
          end
        end
        default: ns = M_IDLE;
      endcase
    end
    if (ns != M_LCK) m_miss = 0;
    if (!dc || e) m_since = 0;
    else if (m_since < 15) m_since = m_since + 1;
    m_ph = al ? ALIGN : (m_ph + 1) % 4;
    m_pin[0] = m_pin[1];
    m_pin[1] = m_pin[2];
    m_pin[2] = pin;
    m_state = ns;
  endtask

  task automatic cyc(input logic pin, input logic dc, input logic ncen);
    @(negedge clk);
    dlclk_n = pin; dc_r = dc; ncen_r = ncen;
    #1;
    last_en = {phil_p, phil_n, phih_p, phih_n};
    chk("enables", int'(last_en), int'(model_en(ncen)));
    if (ncen) model_step(pin, dc);
    @(posedge clk);
    #1;
    chk("state", int'(state), m_state);
    chk("locked", int'(locked), int'(m_state == M_LCK || m_state == M_HLD));
    chk("hold", int'(hold), int'(m_state == M_HLD));
    chk("slip", int'(slip), m_slip);
  endtask

  task automatic ecyc(input logic pin, input logic dc);
    if (slow) begin
      cyc(pin, dc, 1'b0);
      cyc(pin, dc, 1'b0);
    end
    cyc(pin, dc, 1'b1);
  endtask

  task automatic period(input int lo, input int hi, input logic dc);
    repeat (lo) ecyc(1'b0, dc);
    repeat (hi) ecyc(1'b1, dc);
  endtask

  task automatic lock_up();
    repeat (6) period(2, 2, 1'b1);
    chk("lock_state", int'(state), M_LCK);
    chk("lock_locked", int'(locked), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; dc_r = 1'b0; ncen_r = 1'b1; dlclk_n = 1'b1;
    m_reset();
    #1;
    chk("rst_en_ncen1", int'({phil_p, phil_n, phih_p, phih_n}), 4'b1010);
    ncen_r = 1'b0;
    #1;
    chk("rst_en_ncen0", int'({phil_p, phil_n, phih_p, phih_n}), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_slip", int'(slip), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic slip_seq();
    period(2, 3, 1'b1);
    period(2, 2, 1'b1);
    period(2, 2, 1'b1);
    chk("slip_one_cnt", int'(slip), 1);
    chk("slip_one_state", int'(state), M_LCK);
    repeat (3) period(2, 3, 1'b1);
    chk("slip_two_state", int'(state), M_ACQ);
    chk("slip_two_locked", int'(locked), 0);
  endtask

  typedef struct {
    logic       dc;
    logic       ncen;
    logic [3:0] en;
    logic [2:0] st;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   seen, done;
    int   k;
    logic pv;

    tbl[0] = '{1'b0, 1'b1, 4'b1010, 3'd0};
    tbl[1] = '{1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[2] = '{1'b0, 1'b1, 4'b0001, 3'd0};
    tbl[3] = '{1'b0, 1'b1, 4'b0110, 3'd0};
    tbl[4] = '{1'b1, 1'b0, 4'b0000, 3'd0};
    tbl[5] = '{1'b1, 1'b1, 4'b0001, 3'd1};
    tbl[6] = '{1'b1, 1'b1, 4'b1010, 3'd1};
    tbl[7] = '{1'b0, 1'b1, 4'b0001, 3'd0};
    tbl[8] = '{1'b0, 1'b1, 4'b0110, 3'd0};

    rst_n = 1'b1; ncen_r = 1'b0; dc_r = 1'b0; dlclk_n = 1'b1;
    m_reset();
    do_reset();

    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, tbl[i].dc, tbl[i].ncen);
      chk("tbl_en", int'(last_en), int'(tbl[i].en));
      chk("tbl_state", int'(state), int'(tbl[i].st));
    end

    // ideal lock, single slip, double slip
    do_reset();
    lock_up();
    chk("lock_slip0", int'(slip), 0);
    slip_seq();

    // reset while locked drops o_LOCKED immediately, then reacquires
    repeat (3) period(2, 2, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0; ncen_r = 1'b0;
    #1;
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_state", int'(state), 0);
    chk("midrst_slip", int'(slip), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lock_up();

    // period of 5 never locks
    do_reset();
    repeat (10) period(2, 3, 1'b1);
    chk("p5_state", int'(state), M_ACQ);
    chk("p5_locked", int'(locked), 0);

    // stuck high: holdover then give up after 4*TIMEOUT cycles
    do_reset();
    lock_up();
    seen = 0;
    for (int i = 0; i < 12; i++) if (!seen) begin
      ecyc(1'b1, 1'b1);
      if (hold) seen = 1;
    end
    chk("hold_rise", int'(seen), 1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      ecyc(1'b1, 1'b1);
      if (state == 3'd1 && k == 0) k = i;
    end
    chk("hold_to_unlocked", k, 4 * TIMEOUT);

    // stuck high then in-phase restart within holdover
    do_reset();
    lock_up();
    repeat (16) ecyc(1'b1, 1'b1);
    chk("hold_mid", int'(hold), 1);
    period(2, 2, 1'b1);
    period(2, 2, 1'b1);
    chk("relock_state", int'(state), M_LCK);
    chk("relock_hold", int'(hold), 0);

    // i_DC dropped on the cycle an edge is being acted on
    do_reset();
    lock_up();
    done = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        pv = (i < 2) ? 1'b0 : 1'b1;
        if (!done && m_edge()) begin
          ecyc(pv, 1'b0);
          chk("dcdrop_state", int'(state), M_IDLE);
          done = 1;
        end else begin
          ecyc(pv, 1'b1);
        end
      end
    end
    chk("dcdrop_seen", int'(done), 1);

    // same scenarios with the enable on every third clock
    slow = 1;
    do_reset();
    lock_up();
    chk("slow_slip0", int'(slip), 0);
    slip_seq();
    slow = 0;

    // randomized traffic against the model
    do_reset();
    for (int s = 0; s < 80; s++) begin
      int lo, hi, reps, mode, nc;
      logic dcv;
      mode = $urandom_range(0, 7);
      dcv  = ($urandom_range(0, 15) != 0);
      nc   = $urandom_range(0, 1);
      if (mode < 3) begin lo = 2; hi = 2; end
      else begin lo = $urandom_range(1, 3); hi = $urandom_range(1, 4); end
      reps = $urandom_range(1, 8);
      if (mode == 7) begin
        repeat ($urandom_range(5, 50))
          cyc(1'b1, dcv, (nc == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
      end else begin
        repeat (reps) begin
          repeat (lo) cyc(1'b0, dcv, (nc == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
          repeat (hi) cyc(1'b1, dcv, (nc == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
